alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Sequential issue/writeback stage sitting directly upstream of the 8-bit ALU.
- Fetches 16-bit instructions from an instruction memory over a valid-qualified request handshake and decodes them.
- Reads operands from an internal 4x8 register file, drives registered opcode/operands into the combinational ALU, and writes the ALU result back to the register file.
- Forms the control core of the small CPU: start/halt control, program counter, retired-instruction counter.

Parameters:
- PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W.
- CNT_W, 16, width of the retired-instruction counter (saturating).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins execution from PC=0 when IDLE or HALTED, ignored otherwise
- imem_req  output  1  instruction fetch request
- imem_addr  output  PC_W  fetch address, equals PC while imem_req=1
- imem_valid  input  1  instruction data valid; sampled only while imem_req=1
- imem_data  input  16  instruction word
- alu_opcode  output  3  registered ALU operation select (000 add … 111 shift right)
- alu_operand1  output  8  registered ALU operand 1
- alu_operand2  output  8  registered ALU operand 2
- alu_result  input  8  combinational ALU result for the current opcode/operands
- dbg_sel  input  2  register file debug read index
- dbg_data  output  8  combinational read of R[dbg_sel]
- busy  output  1  high in FETCH and EXEC
- done  output  1  high in HALTED
- retired  output  CNT_W  count of retired instructions, HALT included

Behaviour:
- Reset (async, rst=1):
  - State=IDLE; PC=0; R0..R3=0; retired=0.
  - imem_req=0; alu_opcode=0; alu_operand1=0; alu_operand2=0; busy=0; done=0.
  - Reset asserted mid-fetch or mid-exec aborts immediately; no writeback occurs.
- Instruction word:
  - [15:14] class: 00 = ALU reg-reg, 01 = ALU immediate, 10 = LDI, 11 = HALT.
  - [13:11] op; [10:9] rd; [8:7] rs; [7:0] imm.
  - Fields a class does not use are ignored.
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE / HALTED:
  - start=1 -> PC=0, FETCH next cycle.
  - retired is not cleared by start; only rst clears it.
- FETCH:
  - imem_req=1 and imem_addr=PC for every cycle in this state.
  - imem_data is only sampled on a cycle where imem_valid=1; fetch latency is unbounded, and the block waits indefinitely.
  - On the imem_valid=1 cycle, decode imem_data and:
    - class 00: alu_opcode<=op, alu_operand1<=R[rd], alu_operand2<=R[rs].
    - class 01: alu_opcode<=op, alu_operand1<=R[rd], alu_operand2<=imm.
    - class 10: alu_operand1<=imm; alu_opcode and alu_operand2 hold their previous values.
    - class 11: go to HALTED, with the same-cycle side effects retired+=1 (saturating) and PC unchanged. No EXEC cycle.
    - Otherwise go to EXEC; the instruction class is latched internally.
- EXEC (exactly 1 cycle), at the end of the cycle:
  - class 00/01: R[rd]<=alu_result.
  - class 10: R[rd]<=alu_operand1.
  - Then PC<=PC+1 (wrap 2^PC_W-1 -> 0), retired+=1 (saturate at all-ones), go to FETCH.
  - imem_req=0 during EXEC.
- Latency:
  - ALU/LDI instruction = fetch wait cycles + 1 FETCH-accept cycle + 1 EXEC cycle.
  - With zero-wait memory that is 2 cycles per instruction.
- Hazards:
  - None: writeback completes before the next fetch decode reads the register file.
  - Back-to-back dependent instructions see the updated value.
- imem_valid while not in FETCH: ignored.
- start while busy: ignored.
- dbg_data always reflects the current register contents, including the value written on the previous edge.
- Outputs alu_* hold their last values in IDLE, EXEC, and HALTED.

Test Plan:
- Reset then start, zero-wait memory:
  - Program LDI R0,0x05; LDI R1,0x03; ADD R0,R1; HALT.
  - Expect R0=0x08, R1=0x03, done=1, retired=4.
  - First request at addr 0 one cycle after start; 2 cycles per instruction.
- Wait states:
  - Same program with imem_valid delayed 3 cycles per fetch.
  - imem_addr stays stable and imem_req stays high while waiting; identical final registers.
- All ALU ops, immediate form with R2=0xF0 before each:
  - op 001 imm 0x01 -> 0xEF.
  - op 010 -> 0x0F.
  - op 110 -> 0xE0.
  - op 111 -> 0x78.
  - op 101 imm 0xFF -> 0x0F.
  - op 000 imm 0x20 -> 0x10 (wrap).
- PC wrap:
  - 256 consecutive non-HALT instructions followed by a further fetch.
  - imem_addr goes 0xFF -> 0x00.
- Reset mid-EXEC:
  - Assert rst during the EXEC of an ADD.
  - Destination register stays 0; all outputs return to reset values asynchronously.
- start while busy:
  - Pulse start during FETCH -> ignored, PC unchanged.
  - start in HALTED -> restarts at addr 0, retired continues from its prior count.

Source files
------------

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for the 8-bit ALU: fetches, decodes, drives registered ALU operands, writes back.
// Latency: fetch wait cycles + 2 per ALU/LDI instruction; instruction fetch waits indefinitely on imem_valid.
module alu_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [15:0]      imem_data,
  output logic [2:0]       alu_opcode,
  output logic [7:0]       alu_operand1,
  output logic [7:0]       alu_operand2,
  input  logic [7:0]       alu_result,
  input  logic [1:0]       dbg_sel,
  output logic [7:0]       dbg_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

  localparam logic [1:0] C_ALU_RR = 2'b00;
  localparam logic [1:0] C_ALU_RI = 2'b01;
  localparam logic [1:0] C_LDI    = 2'b10;
  localparam logic [1:0] C_HALT   = 2'b11;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [3:0][7:0]   regs_q, regs_d;
  logic [CNT_W-1:0]  retired_q, retired_d, retired_inc;
  logic [2:0]        opc_q, opc_d;
  logic [7:0]        op1_q, op1_d, op2_q, op2_d;
  logic [1:0]        cls_q, cls_d, rd_q, rd_d;

  logic [1:0] f_cls, f_rd, f_rs;
  logic [2:0] f_op;
  logic [7:0] f_imm;

  assign f_cls = imem_data[15:14];
  assign f_op  = imem_data[13:11];
  assign f_rd  = imem_data[10:9];
  assign f_rs  = imem_data[8:7];
  assign f_imm = imem_data[7:0];

  assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    regs_d    = regs_q;
    retired_d = retired_q;
    opc_d     = opc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    cls_d     = cls_q;
    rd_d      = rd_q;
    imem_req  = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          cls_d   = f_cls;
          rd_d    = f_rd;
          state_d = S_EXEC;
          case (f_cls)
            C_ALU_RR: begin
              opc_d = f_op;
              op1_d = regs_q[f_rd];
              op2_d = regs_q[f_rs];
            end
            C_ALU_RI: begin
              opc_d = f_op;
              op1_d = regs_q[f_rd];
              op2_d = f_imm;
            end
            C_LDI:  op1_d = f_imm;
            C_HALT: begin
              // HALT retires in the accept cycle and never enters EXEC.
              state_d   = S_HALTED;
              retired_d = retired_inc;
            end
          endcase
        end
      end
      S_EXEC: begin
        regs_d[rd_q] = (cls_q == C_LDI) ? op1_q : alu_result;
        pc_d         = pc_q + PC_W'(1);
        retired_d    = retired_inc;
        state_d      = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      regs_q    <= '0;
      retired_q <= '0;
      opc_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      cls_q     <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      regs_q    <= regs_d;
      retired_q <= retired_d;
      opc_q     <= opc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      cls_q     <= cls_d;
      rd_q      <= rd_d;
    end
  end

  assign imem_addr    = pc_q;
  assign alu_opcode   = opc_q;
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign dbg_data     = regs_q[dbg_sel];
  assign busy         = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign done         = (state_q == S_HALTED);
  assign retired      = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural ALU and instruction memory, fetch-address scoreboard.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = '0;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_operand1, alu_operand2, alu_result;
  logic [1:0]  dbg_sel = '0;
  logic [7:0]  dbg_data;
  logic        busy, done;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  int wait_cfg = 0;
  logic [15:0] mem [256];
  logic [7:0]  exp_addr [$];

  alu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .busy(busy), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = ~a;
      3'd3: alu_f = a & b;
      3'd4: alu_f = a | b;
      3'd5: alu_f = a ^ b;
      3'd6: alu_f = a << 1;
      default: alu_f = a >> 1;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_operand1, alu_operand2);

  function automatic logic [15:0] i_ldi(input logic [1:0] rd, input logic [7:0] imm);
    i_ldi = {2'b10, 3'b000, rd, 1'b0, imm};
  endfunction
  function automatic logic [15:0] i_rr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
    i_rr = {2'b00, op, rd, rs, 7'b0};
  endfunction
  function automatic logic [15:0] i_ri(input logic [2:0] op, input logic [1:0] rd, input logic [7:0] imm);
    i_ri = {2'b01, op, rd, 1'b0, imm};
  endfunction
  localparam logic [15:0] I_HALT = 16'hC000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
    dbg_sel = r;
    #1;
    chk(tag, {24'b0, dbg_data}, {24'b0, exp});
  endtask

  // Memory responder: answers each fetch after wait_cfg idle cycles, pops the scoreboard on accept.
  initial begin
    int wcnt;
    logic [7:0] hold_addr;
    logic [7:0] e;
    wcnt = 0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req) begin
        if (wcnt == 0) hold_addr = imem_addr;
        else chk("addr_stable", {24'b0, imem_addr}, {24'b0, hold_addr});
        if (wcnt == wait_cfg) begin
          imem_valid = 1'b1;
          imem_data  = mem[imem_addr];
          wcnt = 0;
          if (exp_addr.size() == 0) chk("unexpected_fetch", {24'b0, imem_addr}, 32'hFFFF_FFFF);
          else begin
            e = exp_addr.pop_front();
            chk("fetch_addr", {24'b0, imem_addr}, {24'b0, e});
          end
        end else begin
          imem_valid = 1'b0;
          wcnt++;
        end
      end else begin
        if (!rst && wcnt != 0) chk("req_dropped_in_wait", 32'd0, 32'd1);
        imem_valid = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic run(input string tag, input int wt, input int poke, input int exp_cyc);
    int cyc;
    wait_cfg = wt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_req0"}, {31'b0, imem_req}, 32'd1);
    chk({tag, "_addr0"}, {24'b0, imem_addr}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (cyc == poke);
    end
    start = 1'b0;
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_sb_empty"}, exp_addr.size(), 32'd0);
  endtask

  task automatic load_basic();
    mem[0] = i_ldi(2'd0, 8'h05);
    mem[1] = i_ldi(2'd1, 8'h03);
    mem[2] = i_rr(3'b000, 2'd0, 2'd1);
    mem[3] = I_HALT;
    for (int i = 0; i < 4; i++) exp_addr.push_back(8'(i));
  endtask

  task automatic wait_sb_empty(input string tag);
    int cyc;
    cyc = 0;
    while (exp_addr.size() != 0 && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk({tag, "_sb_drained"}, exp_addr.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_opc"}, {29'b0, alu_opcode}, 32'd0);
    chk({tag, "_op1"}, {24'b0, alu_operand1}, 32'd0);
    chk({tag, "_op2"}, {24'b0, alu_operand2}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_retired"}, {16'b0, retired}, 32'd0);
  endtask

  initial begin
    logic [2:0] ops [6];
    logic [7:0] imms [6];
    logic [7:0] exps [6];
    ops  = '{3'b001, 3'b010, 3'b110, 3'b111, 3'b101, 3'b000};
    imms = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h20};
    exps = '{8'hEF, 8'h0F, 8'hE0, 8'h78, 8'h0F, 8'h10};
    for (int i = 0; i < 256; i++) mem[i] = I_HALT;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    for (int r = 0; r < 4; r++) chk_reg("rst_reg", 2'(r), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    load_basic();
    run("zw", 0, -1, 7);
    chk_reg("zw_r0", 2'd0, 8'h08);
    chk_reg("zw_r1", 2'd1, 8'h03);
    chk("zw_retired", {16'b0, retired}, 32'd4);

    // Restart from HALTED with wait states and a stray start pulse mid-fetch.
    load_basic();
    run("ws", 3, 6, 19);
    chk_reg("ws_r0", 2'd0, 8'h08);
    chk_reg("ws_r1", 2'd1, 8'h03);
    chk("ws_retired", {16'b0, retired}, 32'd8);

    for (int k = 0; k < 6; k++) begin
      mem[0] = i_ldi(2'd2, 8'hF0);
      mem[1] = i_ri(ops[k], 2'd2, imms[k]);
      mem[2] = I_HALT;
      for (int i = 0; i < 3; i++) exp_addr.push_back(8'(i));
      run($sformatf("op%0d", ops[k]), 0, -1, 5);
      chk_reg($sformatf("op%0d_r2", ops[k]), 2'd2, exps[k]);
    end
    chk("ops_retired", {16'b0, retired}, 32'd26);

    for (int i = 0; i < 256; i++) begin
      mem[i] = i_ldi(2'd3, 8'(i));
      exp_addr.push_back(8'(i));
    end
    exp_addr.push_back(8'h00);
    wait_cfg = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_sb_empty("wrap");
    chk_reg("wrap_r3", 2'd3, 8'hFF);
    chk("wrap_retired", {16'b0, retired}, 32'd282);
    rst = 1'b1;
    #1;
    check_reset_outputs("wrap_rst");
    @(negedge clk);
    rst = 1'b0;

    mem[0] = i_ldi(2'd0, 8'h05);
    mem[1] = i_rr(3'b000, 2'd2, 2'd0);
    mem[2] = I_HALT;
    exp_addr.push_back(8'h00);
    exp_addr.push_back(8'h01);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_sb_empty("mid");
    chk("mid_op2_pre", {24'b0, alu_operand2}, 32'h05);
    chk("mid_busy_pre", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    chk_reg("mid_r2", 2'd2, 8'h00);
    chk_reg("mid_r0", 2'd0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_rst_req", {31'b0, imem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
